// File: rtl/pim_dma_cmd_sched_pkg.sv
// ---------------------------------------------------------------------------
// pim_dma_pkg
// Shared types for the PIM DMA command scheduler. It holds:
//   - the funct3 opcodes understood by the DMA,
//   - the queued command record,
//   - the scheduler FSM state encoding,
//   - the command legality check applied at push time.
// ---------------------------------------------------------------------------
package pim_dma_pkg;

    // Width of the size field carried in a queued command.
    localparam int PIM_SIZE_W = 13;

    localparam logic [2:0] PIM_WRITE   = 3'b001;
    localparam logic [2:0] PIM_COMPUTE = 3'b010;
    localparam logic [2:0] PIM_LOAD    = 3'b100;

    typedef struct packed {
        logic [2:0]            funct3;
        logic [3:0]            sel_pim;
        logic [PIM_SIZE_W-1:0] size;
        logic [31:0]           addr;
    } pim_cmd_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } sched_state_e;

    // A command is storable only with a known opcode and a non-zero size.
    function automatic logic cmd_is_legal(input logic [2:0] funct3,
                                          input logic       size_nonzero);
        return ((funct3 == PIM_WRITE) || (funct3 == PIM_COMPUTE) ||
                (funct3 == PIM_LOAD)) && size_nonzero;
    endfunction

endpackage

// File: rtl/pim_dma_cmd_sched_fifo.sv
// ---------------------------------------------------------------------------
// pim_cmd_fifo
// In-order circular queue of pim_cmd_t entries. Pointers carry one extra MSB
// so that full and empty are distinguished without a separate flag.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_push, i_data   write request and entry (ignored while full or flushing)
//   i_pop            drop the head entry (ignored while empty or flushing)
//   i_flush          empty the queue; wins over push and pop
//   o_head           entry at the read pointer
//   o_full, o_empty  occupancy flags
//   o_count          registered number of stored entries
// ---------------------------------------------------------------------------
module pim_cmd_fifo
    import pim_dma_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  pim_cmd_t         i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output pim_cmd_t         o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [CNT_W-1:0] count_q;
    pim_cmd_t         mem [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign o_empty = (wr_ptr == rd_ptr);
    // Same slot but different wrap bit means the writer has lapped the reader.
    assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign o_head  = mem[rd_ptr[AW-1:0]];
    assign o_count = count_q;

    assign push_ok = i_push && !o_full  && !i_flush;
    assign pop_ok  = i_pop  && !o_empty && !i_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (i_flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage carries no reset; only the pointers define validity.
    always_ff @(posedge i_clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/pim_dma_cmd_sched.sv
// ---------------------------------------------------------------------------
// pim_dma_cmd_sched
// Queues PIM commands from the core and issues them one at a time to the
// DMA. Each issue is a one-cycle enable pulse followed by tracking of the
// DMA busy flag (rise, then fall) before the next command may start.
//
// Ports:
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_cmd_valid / o_cmd_ready   core command handshake
//   i_cmd_funct3/sel_pim/size/addr  command fields
//   i_flush                     drop all queued, not yet issued commands
//   o_dma_en                    one-cycle DMA start pulse
//   o_dma_funct3/sel_pim/size/addr  operands, stable from issue to next issue
//   i_dma_busy                  DMA busy status
//   o_cmd_done                  pulse after an issued command completes
//   o_err_illegal               pulse the cycle after an illegal command
//   o_queue_count               registered queue occupancy
//   o_sched_busy                queue non-empty or transfer in progress
// ---------------------------------------------------------------------------
module pim_dma_cmd_sched
    import pim_dma_pkg::*;
#(
    parameter int DEPTH  = 4,
    // Must match PIM_SIZE_W, the size field width of pim_cmd_t.
    parameter int SIZE_W = PIM_SIZE_W,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [2:0]        i_cmd_funct3,
    input  logic [3:0]        i_cmd_sel_pim,
    input  logic [SIZE_W-1:0] i_cmd_size,
    input  logic [31:0]       i_cmd_addr,
    input  logic              i_flush,
    output logic              o_dma_en,
    output logic [2:0]        o_dma_funct3,
    output logic [3:0]        o_dma_sel_pim,
    output logic [SIZE_W-1:0] o_dma_size,
    output logic [31:0]       o_dma_addr,
    input  logic              i_dma_busy,
    output logic              o_cmd_done,
    output logic              o_err_illegal,
    output logic [CNT_W-1:0]  o_queue_count,
    output logic              o_sched_busy
);

    sched_state_e state_q;
    sched_state_e state_d;

    pim_cmd_t cmd_in;
    pim_cmd_t head;
    pim_cmd_t issue_cmd_p1;
    logic     fifo_full;
    logic     fifo_empty;
    logic     accept;
    logic     legal;
    logic     push;
    logic     pop;
    logic     err_vld_p1;
    logic     done_vld_p1;

    // Acceptance: an illegal command is still consumed, just not stored.
    assign o_cmd_ready = !fifo_full && !i_flush;
    assign accept      = i_cmd_valid && o_cmd_ready;
    assign legal       = cmd_is_legal(i_cmd_funct3, |i_cmd_size);
    assign push        = accept && legal;
    assign pop         = (state_q == ISSUE);

    always_comb begin
        cmd_in         = '0;
        cmd_in.funct3  = i_cmd_funct3;
        cmd_in.sel_pim = i_cmd_sel_pim;
        cmd_in.size    = i_cmd_size;
        cmd_in.addr    = i_cmd_addr;
    end

    pim_cmd_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_data  (cmd_in),
        .i_pop   (pop),
        .i_flush (i_flush),
        .o_head  (head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (o_queue_count)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (!fifo_empty && !i_flush) state_d = ISSUE;
            ISSUE:     state_d = WAIT_BUSY;
            WAIT_BUSY: if (i_dma_busy) state_d = WAIT_DONE;
            WAIT_DONE: if (!i_dma_busy) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Stage p1: head is captured on the IDLE->ISSUE transition so the
    // operands are already valid during ISSUE and stay put until the next
    // issue, even if a flush lands in the ISSUE cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            issue_cmd_p1 <= '0;
            err_vld_p1   <= 1'b0;
            done_vld_p1  <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_vld_p1  <= accept && !legal;
            done_vld_p1 <= (state_q == WAIT_DONE) && !i_dma_busy;
            if ((state_q == IDLE) && (state_d == ISSUE)) begin
                issue_cmd_p1 <= head;
            end
        end
    end

    assign o_dma_en      = (state_q == ISSUE);
    assign o_dma_funct3  = issue_cmd_p1.funct3;
    assign o_dma_sel_pim = issue_cmd_p1.sel_pim;
    assign o_dma_size    = issue_cmd_p1.size;
    assign o_dma_addr    = issue_cmd_p1.addr;
    assign o_cmd_done    = done_vld_p1;
    assign o_err_illegal = err_vld_p1;
    assign o_sched_busy  = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_pim_dma_cmd_sched.sv
module tb_pim_dma_cmd_sched;

    localparam int SIZE_W = 13;
    localparam int CNT_W  = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_funct3;
    logic [3:0]        cmd_sel;
    logic [SIZE_W-1:0] cmd_size;
    logic [31:0]       cmd_addr;
    logic              flush;
    logic              dma_en;
    logic [2:0]        dma_funct3;
    logic [3:0]        dma_sel;
    logic [SIZE_W-1:0] dma_size;
    logic [31:0]       dma_addr;
    logic              dma_busy;
    logic              cmd_done;
    logic              err_illegal;
    logic [CNT_W-1:0]  queue_count;
    logic              sched_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pim_dma_cmd_sched dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_cmd_valid   (cmd_valid),
        .o_cmd_ready   (cmd_ready),
        .i_cmd_funct3  (cmd_funct3),
        .i_cmd_sel_pim (cmd_sel),
        .i_cmd_size    (cmd_size),
        .i_cmd_addr    (cmd_addr),
        .i_flush       (flush),
        .o_dma_en      (dma_en),
        .o_dma_funct3  (dma_funct3),
        .o_dma_sel_pim (dma_sel),
        .o_dma_size    (dma_size),
        .o_dma_addr    (dma_addr),
        .i_dma_busy    (dma_busy),
        .o_cmd_done    (cmd_done),
        .o_err_illegal (err_illegal),
        .o_queue_count (queue_count),
        .o_sched_busy  (sched_busy)
    );

    // DMA model: busy rises the cycle after the enable, lasts busy_len cycles.
    int busy_len = 10;
    int busy_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)            busy_cnt <= 0;
        else if (dma_en)       busy_cnt <= busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign dma_busy = (busy_cnt > 0);

    // Issue / completion log.
    int          en_cnt   = 0;
    int          done_cnt = 0;
    logic [31:0] log_addr [64];
    logic [2:0]  log_f3   [64];
    always @(posedge clk) begin
        if (dma_en) begin
            log_addr[en_cnt % 64] <= dma_addr;
            log_f3[en_cnt % 64]   <= dma_funct3;
            en_cnt                <= en_cnt + 1;
        end
        if (cmd_done) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] f3, input logic [3:0] sel,
                         input logic [SIZE_W-1:0] sz, input logic [31:0] addr);
        cmd_valid  = v;
        cmd_funct3 = f3;
        cmd_sel    = sel;
        cmd_size   = sz;
        cmd_addr   = addr;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int en0;
    int d0;
    int waited;
    logic [2:0] t2_f3 [6];
    logic [31:0] exp_addr;
    logic [CNT_W-1:0] peak;

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        drive(1'b0, 3'd0, 4'd0, '0, 32'd0);
        t2_f3 = '{3'b001, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010};

        // Reset state
        tick();
        tick();
        chk("rst_ready", cmd_ready, 1);
        chk("rst_dma_en", dma_en, 0);
        chk("rst_done", cmd_done, 0);
        chk("rst_err", err_illegal, 0);
        chk("rst_count", queue_count, 0);
        chk("rst_sched_busy", sched_busy, 0);
        chk("rst_dma_addr", dma_addr, 0);
        rst_n = 1'b1;
        tick();

        // Single command, busy 20 cycles
        busy_len = 20;
        en0 = en_cnt;
        d0  = done_cnt;
        drive(1'b1, 3'b001, 4'd3, 13'd16, 32'h1000);
        #1;
        chk("t1_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        chk("t1_count_after_push", queue_count, 1);
        chk("t1_en_early", dma_en, 0);
        chk("t1_sched_busy", sched_busy, 1);
        tick();
        chk("t1_en", dma_en, 1);
        chk("t1_f3", dma_funct3, 3'b001);
        chk("t1_sel", dma_sel, 4'd3);
        chk("t1_size", dma_size, 16);
        chk("t1_addr", dma_addr, 32'h1000);
        tick();
        chk("t1_en_single", dma_en, 0);
        chk("t1_count_after_pop", queue_count, 0);
        repeat (19) tick();
        chk("t1_busy_last", dma_busy, 1);
        chk("t1_done_early", cmd_done, 0);
        tick();
        chk("t1_busy_fell", dma_busy, 0);
        chk("t1_done_not_yet", cmd_done, 0);
        tick();
        chk("t1_done", cmd_done, 1);
        tick();
        chk("t1_done_single", cmd_done, 0);
        chk("t1_idle", sched_busy, 0);
        chk("t1_en_total", en_cnt - en0, 1);
        chk("t1_done_total", done_cnt - d0, 1);

        // Fill queue while DMA busy: Z then A..E
        busy_len = 10;
        en0 = en_cnt;
        drive(1'b1, t2_f3[0], 4'd0, 13'd1, 32'h2000);
        tick();
        drive(1'b1, t2_f3[1], 4'd1, 13'd2, 32'h3000);
        tick();
        chk("t2_issue_z", dma_en, 1);
        chk("t2_issue_z_addr", dma_addr, 32'h2000);
        drive(1'b1, t2_f3[2], 4'd2, 13'd3, 32'h3010);
        tick();
        drive(1'b1, t2_f3[3], 4'd3, 13'd4, 32'h3020);
        tick();
        chk("t2_count3", queue_count, 3);
        drive(1'b1, t2_f3[4], 4'd4, 13'd5, 32'h3030);
        tick();
        chk("t2_count_full", queue_count, 4);
        drive(1'b1, t2_f3[5], 4'd5, 13'd6, 32'h3040);
        #1;
        chk("t2_ready_full", cmd_ready, 0);
        peak = queue_count;
        waited = 0;
        while (!cmd_ready && waited < 40) begin
            tick();
            waited++;
            if (queue_count > peak) peak = queue_count;
        end
        chk("t2_wait_for_pop", waited, 11);
        tick();
        cmd_valid = 1'b0;
        waited = 0;
        while ((en_cnt - en0) < 6 && waited < 200) begin
            if (queue_count > peak) peak = queue_count;
            tick();
            waited++;
        end
        chk("t2_all_issued", en_cnt - en0, 6);
        chk("t2_peak", peak, 4);
        for (int i = 0; i < 6; i++) begin
            exp_addr = (i == 0) ? 32'h2000 : 32'h3000 + 32'(i - 1) * 32'h10;
            chk("t2_order_addr", log_addr[(en0 + i) % 64], exp_addr);
            chk("t2_order_f3", log_f3[(en0 + i) % 64], t2_f3[i]);
        end
        waited = 0;
        while (sched_busy && waited < 40) begin
            tick();
            waited++;
        end
        chk("t2_drained", sched_busy, 0);
        tick();

        // Illegal commands
        en0 = en_cnt;
        drive(1'b1, 3'b011, 4'd1, 13'd5, 32'h4000);
        #1;
        chk("t3_ready_bad_f3", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        chk("t3_err_f3", err_illegal, 1);
        chk("t3_count_f3", queue_count, 0);
        tick();
        chk("t3_err_f3_single", err_illegal, 0);
        drive(1'b1, 3'b001, 4'd1, 13'd0, 32'h4000);
        tick();
        cmd_valid = 1'b0;
        chk("t3_err_size0", err_illegal, 1);
        chk("t3_count_size0", queue_count, 0);
        tick();
        chk("t3_err_size0_single", err_illegal, 0);
        repeat (5) tick();
        chk("t3_no_issue", en_cnt - en0, 0);
        chk("t3_idle", sched_busy, 0);

        // Flush during WAIT_DONE
        busy_len = 10;
        en0 = en_cnt;
        d0  = done_cnt;
        drive(1'b1, 3'b001, 4'd1, 13'd8, 32'h5000);
        tick();
        drive(1'b1, 3'b010, 4'd2, 13'd8, 32'h5100);
        tick();
        drive(1'b1, 3'b100, 4'd3, 13'd8, 32'h5200);
        chk("t4_issue_first", dma_en, 1);
        chk("t4_issue_addr", dma_addr, 32'h5000);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("t4_count_before_flush", queue_count, 2);
        flush = 1'b1;
        #1;
        chk("t4_ready_flush", cmd_ready, 0);
        tick();
        flush = 1'b0;
        chk("t4_count_after_flush", queue_count, 0);
        repeat (8) tick();
        chk("t4_done", cmd_done, 1);
        repeat (20) tick();
        chk("t4_issue_total", en_cnt - en0, 1);
        chk("t4_done_total", done_cnt - d0, 1);
        chk("t4_idle", sched_busy, 0);

        // Valid and flush together
        en0 = en_cnt;
        drive(1'b1, 3'b001, 4'd1, 13'd4, 32'h6000);
        flush = 1'b1;
        #1;
        chk("t5_ready", cmd_ready, 0);
        tick();
        cmd_valid = 1'b0;
        flush     = 1'b0;
        chk("t5_count", queue_count, 0);
        repeat (4) tick();
        chk("t5_no_issue", en_cnt - en0, 0);

        // Reset during WAIT_DONE with 2 queued
        busy_len = 10;
        drive(1'b1, 3'b001, 4'd1, 13'd8, 32'h7000);
        tick();
        drive(1'b1, 3'b010, 4'd2, 13'd8, 32'h7100);
        tick();
        drive(1'b1, 3'b100, 4'd3, 13'd8, 32'h7200);
        chk("t6_issue_first", dma_en, 1);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("t6_count_before", queue_count, 2);
        rst_n = 1'b0;
        #1;
        chk("t6_count", queue_count, 0);
        chk("t6_sched_busy", sched_busy, 0);
        chk("t6_dma_en", dma_en, 0);
        chk("t6_done", cmd_done, 0);
        chk("t6_err", err_illegal, 0);
        chk("t6_ready", cmd_ready, 1);
        tick();
        rst_n = 1'b1;
        en0 = en_cnt;
        repeat (30) tick();
        chk("t6_no_issue", en_cnt - en0, 0);
        chk("t6_idle", sched_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pim_dma_cmd_sched.md
Name: pim_dma_cmd_sched

Overview:
Command scheduler in front of the PIM DMA engine. The core posts PIM commands (write, compute or load, plus PIM select, transfer size and memory address) into a small in-order queue. The scheduler issues them one at a time to the DMA: it pulses the DMA enable, then tracks the DMA busy flag until the transfer completes. It sits between the core's custom-instruction decode and the DMA, so the core never stalls on a busy DMA unless the queue is full.

Parameters:
DEPTH, 4, queue entries; must be a power of 2 and at least 2.
SIZE_W, 13, width of the transfer-size field, in words.
CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_cmd_valid  in  1  core command valid
o_cmd_ready  out  1  scheduler can accept a command this cycle
i_cmd_funct3  in  3  001 = pim_write, 010 = pim_compute, 100 = pim_load
i_cmd_sel_pim  in  4  PIM macro select
i_cmd_size  in  SIZE_W  transfer count, in words
i_cmd_addr  in  32  memory base address
i_flush  in  1  discard all queued commands that have not yet been issued
o_dma_en  out  1  one-cycle start pulse to the DMA
o_dma_funct3  out  3  operand to the DMA
o_dma_sel_pim  out  4  operand to the DMA
o_dma_size  out  SIZE_W  operand to the DMA
o_dma_addr  out  32  operand to the DMA
i_dma_busy  in  1  DMA busy status
o_cmd_done  out  1  one-cycle pulse when an issued command completes
o_err_illegal  out  1  one-cycle pulse when a command is rejected
o_queue_count  out  CNT_W  number of queued entries
o_sched_busy  out  1  queue non-empty, or FSM not in IDLE

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - queue empty, pointers 0, FSM in IDLE.
  - All outputs 0, except o_cmd_ready = 1.
- Queue:
  - Circular FIFO with pointers of log2(DEPTH)+1 bits; wrap-around is via the MSB.
  - o_cmd_ready = !full && !i_flush.
  - A push occurs when i_cmd_valid && o_cmd_ready.
  - When full, no push is accepted even if a pop happens in the same cycle.
  - Push and pop in the same non-full cycle leave the count unchanged.
- Validation at push:
  - A command is illegal if funct3 is not one of 001, 010, 100, or if size == 0.
  - An illegal command is consumed (ready honoured) but not stored.
  - o_err_illegal pulses in the cycle after acceptance.
- FSM states and transitions:
  - IDLE: if the queue is non-empty and i_flush = 0, go to ISSUE.
  - ISSUE (1 cycle):
    - o_dma_en = 1.
    - The o_dma_* operands come from the head-entry registers and are held stable from this cycle until the next ISSUE.
    - Pop the head; go to WAIT_BUSY.
  - WAIT_BUSY: when i_dma_busy = 1, go to WAIT_DONE. The DMA raises busy one cycle after the enable.
  - WAIT_DONE: when i_dma_busy = 0, pulse o_cmd_done and go to IDLE.
- Latency:
  - Command accepted into an empty queue with the FSM in IDLE → o_dma_en 2 cycles later (push cycle, IDLE cycle, ISSUE).
  - Minimum spacing between consecutive o_dma_en pulses is 4 cycles.
- Flush:
  - Empties the queue in the cycle it is asserted, and takes priority over any push in that cycle.
  - The in-flight command (WAIT_BUSY or WAIT_DONE) is not aborted; it completes and o_cmd_done still pulses.
  - A flush during ISSUE does not cancel that issue.
- Status outputs:
  - o_dma_en is never asserted outside ISSUE.
  - o_queue_count is registered and reflects the count after the current cycle's push, pop and flush.

Decomposition:
- Shared package pim_dma_pkg:
  - funct3 constants PIM_WRITE, PIM_COMPUTE, PIM_LOAD.
  - Packed struct pim_cmd_t {funct3, sel_pim, size, addr}.
  - FSM state enum {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE}.
- Sub-module pim_cmd_fifo: the parameterised FIFO of pim_cmd_t with push, pop, flush, full, empty and count.
- Validation, FSM and DMA-side registers stay in the top module.

Test Plan:
- Single command (funct3 = 001, sel = 3, size = 16, addr = 0x1000) into an empty queue, DMA model asserts busy for 20 cycles:
  - o_dma_en is one pulse exactly 2 cycles after acceptance, with operands 001/3/16/0x1000.
  - o_cmd_done pulses once, in the cycle after busy falls.
- Push 5 legal commands back-to-back with DEPTH = 4 while the DMA is busy:
  - the 5th command sees o_cmd_ready = 0 until a pop occurs;
  - all 5 are issued in order;
  - o_queue_count peaks at 4.
- Illegal commands, funct3 = 011 and, separately, size = 0:
  - each is accepted and o_err_illegal pulses once;
  - the count stays 0 and o_dma_en is never asserted.
- Queue 3 commands, then assert i_flush while the first is in WAIT_DONE:
  - the first still completes with o_cmd_done;
  - the remaining 2 are never issued;
  - the count is 0 in the cycle after the flush.
- i_cmd_valid and i_flush in the same cycle:
  - the command is not accepted (ready = 0) and the count stays 0.
- Drop i_rst_n during WAIT_DONE with 2 entries queued:
  - the FSM goes immediately to IDLE and the count to 0;
  - o_dma_en, o_cmd_done and o_err_illegal are 0 and o_cmd_ready is 1;
  - after release, no command is issued.
